prio_arb: RTL and testbench



---
 rtl/prio_arb.sv | 148 ++++++++++++++
 tb/tb_prio_arb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/prio_arb.sv
// prio_arb: registered N-way priority arbiter with valid/ready grant handshake.
//
// Samples the request vector, picks one winner and holds it stable until the
// consumer accepts it. On accept with requests still pending it re-arbitrates
// in the same edge, so grants can issue back to back.
//
// Build option:
//   PRIO_ARB_RR_EN  defined   -> round-robin; the last accepted requester
//                                gets the lowest priority.
//                   undefined -> fixed priority, highest index wins.
//
// Parameters:
//   N  number of requesters (>= 2)
//   W  width of the grant index
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req         request vector, bit i = requester i
//   gnt_ready   consumer accepts the presented grant
//   gnt_valid   a grant is presented
//   gnt_idx     binary index of the granted requester
//   gnt_onehot  one-hot form of gnt_idx, zero while gnt_valid = 0
module prio_arb #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] oh_q, oh_d;
    logic [W-1:0] win_idx;
    logic         any_req;

    assign any_req = |req;

`ifdef PRIO_ARB_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] base;

    // On an accept the grant being retired is the new "last served" entry,
    // so search from it directly rather than from the stale pointer.
    assign base = (state_q == StGrant) ? idx_q : ptr_q;

    // Search base-1, base-2, ... (mod N), ending with base itself.
    always_comb begin
        logic found;
        int unsigned pos;
        found   = 1'b0;
        pos     = 0;
        win_idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = (32'(base) + N - k) % N;
            if (!found && req[pos]) begin
                win_idx = W'(pos);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StGrant && gnt_ready) begin
            ptr_d = idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Later (higher) indices overwrite earlier ones: highest index wins.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                win_idx = W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d       = StGrant;
                    idx_d         = win_idx;
                    oh_d          = '0;
                    oh_d[win_idx] = 1'b1;
                end
            end
            StGrant: begin
                // Without ready the grant is frozen regardless of req.
                if (gnt_ready) begin
                    if (any_req) begin
                        idx_d         = win_idx;
                        oh_d          = '0;
                        oh_d[win_idx] = 1'b1;
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                        oh_d    = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
                oh_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
        end
    end

    assign gnt_valid  = (state_q == StGrant);
    assign gnt_idx    = idx_q;
    assign gnt_onehot = oh_q;

endmodule

// File: tb/tb_prio_arb.sv
// tb_prio_arb: directed, table-driven bench for prio_arb with N = 4.
module tb_prio_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         gnt_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;

    int n_checks;
    int n_pass;

    prio_arb #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         ready;
        logic         exp_valid;
        logic [W-1:0] exp_idx;
        logic [N-1:0] exp_oh;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic v, input logic [W-1:0] i,
                              input logic [N-1:0] oh);
        check({name, ".valid"}, int'(gnt_valid), int'(v));
        check({name, ".idx"}, int'(gnt_idx), int'(i));
        check({name, ".onehot"}, int'(gnt_onehot), int'(oh));
    endtask

    task automatic step(input logic [N-1:0] r, input logic rdy);
        @(negedge clk);
        req       = r;
        gnt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    int exp_seq [5];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        req       = '0;
        gnt_ready = 1'b0;

        // Empty/wake, fixed select, stall/hold with request change, accept to idle.
        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[3]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001};
        vecs[4]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[5]  = '{4'b1100, 1'b1, 1'b1, 2'd3, 4'b1000};
        vecs[6]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0100};
        vecs[7]  = '{4'b1000, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[8]  = '{4'b1000, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[9]  = '{4'b1000, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[10] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};

        #12;
        check_outs("reset_state", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].req, vecs[v].ready);
            check_outs($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_idx,
                       vecs[v].exp_oh);
        end

        // Asynchronous reset while holding grant idx 2.
        step(4'b0100, 1'b0);
        check_outs("pre_reset_grant", 1'b1, 2'd2, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_reset", 1'b0, 2'd0, 4'b0000);
        @(posedge clk);
        #1;
        check_outs("reset_held", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("reset_released", 1'b0, 2'd0, 4'b0000);
        @(posedge clk);
        #1;
        check_outs("first_edge_after_reset", 1'b1, 2'd2, 4'b0100);

        // Full requests with ready held, starting from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        gnt_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`ifdef PRIO_ARB_RR_EN
        exp_seq = '{3, 2, 1, 0, 3};
`else
        exp_seq = '{3, 3, 3, 3, 3};
`endif
        for (int s = 0; s < 5; s++) begin
            step(4'b1111, 1'b1);
            check_outs($sformatf("all_req%0d", s), 1'b1, W'(exp_seq[s]),
                       N'(1) << exp_seq[s]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
